// File: rtl/esp_dma_pkg.sv
// esp_dma_pkg: shared burst-state encoding and DMA beat size codes
package esp_dma_pkg;
  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_e;
  localparam logic [2:0] SIZE_8  = 3'b000;
  localparam logic [2:0] SIZE_16 = 3'b001;
  localparam logic [2:0] SIZE_32 = 3'b010;
  localparam logic [2:0] SIZE_64 = 3'b011;
endpackage

// File: rtl/esp_dma_mem.sv
// esp_dma_mem: 64-bit word memory with DMA and backdoor read ports, DMA write wins over backdoor
module esp_dma_mem #(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [63:0]       dma_wdata,
  output logic [63:0]       dma_rdata,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [63:0]       bd_wdata,
  output logic [63:0]       bd_rdata
);
  logic [63:0] mem_q [MEM_WORDS];
  assign dma_rdata = mem_q[dma_addr];
  assign bd_rdata  = mem_q[bd_addr];
  // the later non-blocking write takes effect on a same-word collision
  always_ff @(posedge clk) begin
    if (bd_we) mem_q[bd_addr] <= bd_wdata;
    if (dma_we) mem_q[dma_addr] <= dma_wdata;
  end
endmodule

// File: rtl/esp_dma64_mem_responder.sv
// esp_dma64_mem_responder: memory-backed responder for an ESP 64-bit DMA read/write interface
module esp_dma64_mem_responder
  import esp_dma_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  localparam int ADDR_W = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_read_ctrl_valid,
  input  logic [31:0]       dma_read_ctrl_data_index,
  input  logic [31:0]       dma_read_ctrl_data_length,
  input  logic [2:0]        dma_read_ctrl_data_size,
  output logic              dma_read_ctrl_ready,
  output logic              dma_read_chnl_valid,
  output logic [63:0]       dma_read_chnl_data,
  input  logic              dma_read_chnl_ready,
  input  logic              dma_write_ctrl_valid,
  input  logic [31:0]       dma_write_ctrl_data_index,
  input  logic [31:0]       dma_write_ctrl_data_length,
  input  logic [2:0]        dma_write_ctrl_data_size,
  output logic              dma_write_ctrl_ready,
  input  logic              dma_write_chnl_valid,
  input  logic [63:0]       dma_write_chnl_data,
  output logic              dma_write_chnl_ready,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [63:0]       bd_wdata,
  output logic [63:0]       bd_rdata,
  output logic              busy,
  output logic [15:0]       rd_txn_count,
  output logic [15:0]       wr_txn_count,
  output logic              size_err
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] rem_q, rem_d, len;
  logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic size_err_q, size_err_d;
  logic idle, rd_hs, wr_hs, rd_beat, wr_beat;
  logic [2:0] sz;
  logic unused_idx;
  assign idle    = state_q == IDLE;
  assign rd_hs   = idle && dma_read_ctrl_valid;
  assign wr_hs   = idle && !dma_read_ctrl_valid && dma_write_ctrl_valid;
  assign rd_beat = state_q == RD_BURST && dma_read_chnl_ready;
  assign wr_beat = state_q == WR_BURST && dma_write_chnl_valid;
  assign len     = rd_hs ? dma_read_ctrl_data_length : dma_write_ctrl_data_length;
  assign sz      = rd_hs ? dma_read_ctrl_data_size : dma_write_ctrl_data_size;
  assign unused_idx = ^{dma_read_ctrl_data_index[31:ADDR_W], dma_write_ctrl_data_index[31:ADDR_W]};
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    size_err_d = size_err_q;
    if (rd_hs || wr_hs) begin
      addr_d = rd_hs ? dma_read_ctrl_data_index[ADDR_W-1:0] : dma_write_ctrl_data_index[ADDR_W-1:0];
      rem_d = len;
      size_err_d = size_err_q || sz != SIZE_64;
      if (len != 32'd0) begin
        state_d = rd_hs ? RD_BURST : WR_BURST;
        rd_cnt_d = rd_cnt_q + 16'(rd_hs);
        wr_cnt_d = wr_cnt_q + 16'(wr_hs);
      end
    end
    if (rd_beat || wr_beat) begin
      addr_d = addr_q + ADDR_W'(1);
      rem_d = rem_q - 32'd1;
      state_d = rem_q == 32'd1 ? IDLE : state_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      size_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      size_err_q <= size_err_d;
    end
  end
  assign dma_read_ctrl_ready  = idle;
  assign dma_write_ctrl_ready = idle && !dma_read_ctrl_valid;
  assign dma_read_chnl_valid  = state_q == RD_BURST;
  assign dma_write_chnl_ready = state_q == WR_BURST;
  assign busy = !idle;
  assign rd_txn_count = rd_cnt_q;
  assign wr_txn_count = wr_cnt_q;
  assign size_err = size_err_q;
  // a burst aborted by reset must not commit its in-flight beat
  esp_dma_mem #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk),
    .dma_we(wr_beat && !rst),
    .dma_addr(addr_q),
    .dma_wdata(dma_write_chnl_data),
    .dma_rdata(dma_read_chnl_data),
    .bd_we(bd_we),
    .bd_addr(bd_addr),
    .bd_wdata(bd_wdata),
    .bd_rdata(bd_rdata)
  );
endmodule

// File: tb/tb_esp_dma64_mem_responder.sv
// tb_esp_dma64_mem_responder: transaction-level memory model with per-cycle compare plus directed literal checks
module tb_esp_dma64_mem_responder;
  localparam int W = 16;
  logic clk = 0, rst = 1;
  logic rv = 0, rcr = 1, wv = 0, wcv = 0, bd_we = 0;
  logic [31:0] ri = 0, rl = 0, wi = 0, wl = 0;
  logic [2:0] rs = 3, ws = 3;
  logic [63:0] wd = 0, bd_wdata = 0;
  logic [3:0] bd_addr = 0;
  logic rcrdy, rchv, wcrdy, wchr, busy, size_err;
  logic [63:0] rdata, bd_rdata;
  logic [15:0] rcnt, wcnt;
  int n_pass = 0, n_tot = 0;
  bit chk_en = 0;
  logic [63:0] mm [W];
  int m_mode = 0, m_addr = 0, m_left = 0, m_rd = 0, m_wr = 0;
  bit m_err = 0;
  logic [63:0] got [5];

  esp_dma64_mem_responder #(.MEM_WORDS(W)) dut (
    .clk(clk), .rst(rst),
    .dma_read_ctrl_valid(rv), .dma_read_ctrl_data_index(ri), .dma_read_ctrl_data_length(rl),
    .dma_read_ctrl_data_size(rs), .dma_read_ctrl_ready(rcrdy),
    .dma_read_chnl_valid(rchv), .dma_read_chnl_data(rdata), .dma_read_chnl_ready(rcr),
    .dma_write_ctrl_valid(wv), .dma_write_ctrl_data_index(wi), .dma_write_ctrl_data_length(wl),
    .dma_write_ctrl_data_size(ws), .dma_write_ctrl_ready(wcrdy),
    .dma_write_chnl_valid(wcv), .dma_write_chnl_data(wd), .dma_write_chnl_ready(wchr),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata),
    .busy(busy), .rd_txn_count(rcnt), .wr_txn_count(wcnt), .size_err(size_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // model: a request starts a burst of `length` beats at index mod W; each accepted beat moves one word
  always @(posedge clk) begin
    if (bd_we) mm[bd_addr] = bd_wdata;
    if (rst) begin
      m_mode = 0; m_addr = 0; m_left = 0; m_rd = 0; m_wr = 0; m_err = 0;
    end else if (m_mode == 0) begin
      if (rv || wv) begin
        if ((rv ? rs : ws) != 3'b011) m_err = 1;
        if ((rv ? rl : wl) != 0) begin
          m_mode = rv ? 1 : 2;
          m_addr = int'((rv ? ri : wi) % 32'(W));
          m_left = int'(rv ? rl : wl);
          if (rv) m_rd = (m_rd + 1) % 65536; else m_wr = (m_wr + 1) % 65536;
        end
      end
    end else if ((m_mode == 1 && rcr) || (m_mode == 2 && wcv)) begin
      if (m_mode == 2) mm[m_addr] = wd;
      m_addr = (m_addr + 1) % W;
      m_left--;
      if (m_left == 0) m_mode = 0;
    end
  end

  always @(negedge clk) if (chk_en) begin
    check("rd_ctrl_ready", rcrdy, m_mode == 0);
    check("wr_ctrl_ready", wcrdy, m_mode == 0 && !rv);
    check("rd_chnl_valid", rchv, m_mode == 1);
    check("wr_chnl_ready", wchr, m_mode == 2);
    check("busy", busy, m_mode != 0);
    check("rd_txn_count", rcnt, 64'(m_rd));
    check("wr_txn_count", wcnt, 64'(m_wr));
    check("size_err", size_err, m_err);
    check("bd_rdata", bd_rdata, mm[bd_addr]);
    if (m_mode == 1) check("rd_data", rdata, mm[m_addr]);
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    step();
    chk_en = 1;
    check("reset_busy", busy, 0);
    check("reset_rcnt", rcnt, 0);
    check("reset_err", size_err, 0);
    bd_we = 1;
    for (int i = 0; i < W; i++) begin
      bd_addr = 4'(i);
      bd_wdata = i < 4 ? 64'h11 * 64'(i + 1) : 64'h100 + 64'(i);
      step();
    end
    bd_we = 0; bd_addr = 0; rst = 0;
    step();
    // four-beat read at full rate
    rv = 1; ri = 0; rl = 4; rs = 3;
    step();
    rv = 0;
    for (int i = 0; i < 4; i++) begin
      got[i] = rdata;
      check("t1_valid", rchv, 1);
      step();
    end
    check("t1_d0", got[0], 64'h11);
    check("t1_d1", got[1], 64'h22);
    check("t1_d2", got[2], 64'h33);
    check("t1_d3", got[3], 64'h44);
    check("t1_busy_end", busy, 0);
    check("t1_rcnt", rcnt, 1);
    // three-beat read with back-pressure
    rv = 1; ri = 4; rl = 3;
    step();
    rv = 0;
    for (int k = 0; k < 5; k++) begin
      rcr = k % 2 == 0;
      got[k] = rdata;
      check("t2_busy", busy, 1);
      step();
    end
    rcr = 1;
    check("t2_d0", got[0], 64'h104);
    check("t2_d1", got[1], 64'h105);
    check("t2_hold", got[2], 64'h105);
    check("t2_d2", got[4], 64'h106);
    check("t2_busy_end", busy, 0);
    // wrapping write, DMA beat collides with a backdoor write
    wv = 1; wi = W - 1; wl = 2; ws = 3;
    step();
    wv = 0; wcv = 1; wd = 64'hA;
    bd_we = 1; bd_addr = 4'(W - 1); bd_wdata = 64'hFF;
    step();
    bd_we = 0; wd = 64'hB;
    step();
    wcv = 0; bd_addr = 4'(W - 1);
    #1 check("t3_top", bd_rdata, 64'hA);
    bd_addr = 0;
    #1 check("t3_wrap", bd_rdata, 64'hB);
    check("t3_wcnt", wcnt, 1);
    // simultaneous read and write requests
    rv = 1; ri = 32'h100 + 1; rl = 2; wv = 1; wi = 8; wl = 1;
    #1 check("t4_wr_blocked", wcrdy, 0);
    step();
    rv = 0;
    check("t4_rd_first", rchv, 1);
    check("t4_wr_wait", wcrdy, 0);
    step();
    step();
    check("t4_wr_ready", wcrdy, 1);
    step();
    wv = 0; wcv = 1; wd = 64'h55;
    step();
    wcv = 0; bd_addr = 8;
    #1 check("t4_wdata", bd_rdata, 64'h55);
    check("t4_rcnt", rcnt, 3);
    check("t4_wcnt", wcnt, 2);
    // zero-length request with a 32-bit size code
    rv = 1; ri = 3; rl = 0; rs = 3'b010;
    step();
    rv = 0; rs = 3;
    step();
    check("t5_busy", busy, 0);
    check("t5_err", size_err, 1);
    check("t5_rcnt", rcnt, 3);
    // reset mid write burst
    wv = 1; wi = 10; wl = 4;
    step();
    wv = 0; wcv = 1; wd = 64'hDEAD;
    step();
    wd = 64'hBEEF; rst = 1;
    step();
    rst = 0;
    check("t6_wchr", wchr, 0);
    check("t6_busy", busy, 0);
    check("t6_err", size_err, 0);
    check("t6_wcnt", wcnt, 0);
    step();
    wcv = 0;
    for (int a = 10; a < 13; a++) begin
      bd_addr = 4'(a);
      #1 check("t6_mem", bd_rdata, a == 10 ? 64'hDEAD : 64'h100 + 64'(a));
    end
    step();
    step();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
